// File: rtl/analog_update_responder.sv
// Responder side of the analog value-update handshake.
// Queues requests, fetches one sample each, settles, then acks.
module analog_update_responder #(
  parameter int WIDTH    = 16,
  parameter int SETTLE_W = 4,
  parameter int PEND_W   = 3
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                req,
  output logic                ack,
  output logic [WIDTH-1:0]    value,
  input  logic [WIDTH-1:0]    src_data,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [PEND_W-1:0]   pending,
  output logic                busy,
  output logic                overflow,
  input  logic                ovf_clr
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SETTLE,
    ACK
  } state_t;

  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [SETTLE_W-1:0] CNT_ONE = SETTLE_W'(1);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]    sample;
  logic [SETTLE_W-1:0] cnt;
  logic [PEND_W-1:0]   pend;
  logic                xfer;
  logic                deq;
  logic                drop;
  logic                enter_ack;

  assign xfer = src_valid && (state == FETCH);
  assign deq  = ((state == IDLE) || (state == ACK)) && (pend != '0);
  assign drop = req && !deq && (pend == PMAX);

  assign enter_ack = (state_nx == ACK) && (state != ACK);

  assign src_ready = (state == FETCH);
  assign busy      = (state != IDLE);
  assign pending   = pend;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (deq) state_nx = FETCH;
      end
      FETCH: begin
        if (xfer) begin
          if (settle_cycles == '0) state_nx = ACK;
          else                     state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_ONE) state_nx = ACK;
      end
      ACK: begin
        state_nx = deq ? FETCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= IDLE;
      sample <= '0;
      cnt    <= '0;
      value  <= '0;
      ack    <= 1'b0;
    end else begin
      state <= state_nx;
      ack   <= (state_nx == ACK);
      if (xfer) begin
        sample <= src_data;
        cnt    <= settle_cycles;
      end else if (state == SETTLE) begin
        cnt <= cnt - CNT_ONE;
      end
      // zero-settle captures and delivers on the same edge
      if (enter_ack) begin
        value <= (state == FETCH) ? src_data : sample;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      if (req && !deq && (pend != PMAX)) begin
        pend <= pend + PEND_W'(1);
      end else if (!req && deq) begin
        pend <= pend - PEND_W'(1);
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_analog_update_responder.sv
// Scoreboard bench for analog_update_responder.
// Directed vectors; a negedge monitor checks every ack.
module tb_analog_update_responder;

  logic        clk;
  logic        rstb;
  logic        req;
  logic        ack;
  logic [15:0] value;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [3:0]  settle_cycles;
  logic [2:0]  pending;
  logic        busy;
  logic        overflow;
  logic        ovf_clr;

  analog_update_responder #(
    .WIDTH(16),
    .SETTLE_W(4),
    .PEND_W(3)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .req(req),
    .ack(ack),
    .value(value),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .settle_cycles(settle_cycles),
    .pending(pending),
    .busy(busy),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [15:0] v;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
    end
  endtask

  task automatic to_cycle(input int c);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] v, input int c);
    exp_t e;
    e.v = v;
    e.c = c;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.c));
        chk("ack_value", 32'(value), 32'(e.v));
      end
    end
  end

  initial begin
    rstb          = 1'b0;
    req           = 1'b0;
    src_data      = 16'h0000;
    src_valid     = 1'b1;
    settle_cycles = 4'd0;
    ovf_clr       = 1'b0;

    to_cycle(1);
    #3;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    to_cycle(3);
    rstb = 1'b1;

    // single request, S=0
    to_cycle(9);
    src_data = 16'h1234;
    to_cycle(10);
    req = 1'b1;
    push(16'h1234, 13);
    to_cycle(11);
    req = 1'b0;
    #3;
    chk("t1_busy11", 32'(busy), 0);
    chk("t1_pend11", 32'(pending), 1);
    to_cycle(12);
    #3;
    chk("t1_busy12", 32'(busy), 1);
    chk("t1_ready12", 32'(src_ready), 1);
    chk("t1_pend12", 32'(pending), 0);
    to_cycle(13);
    #3;
    chk("t1_busy13", 32'(busy), 1);
    to_cycle(14);
    #3;
    chk("t1_busy14", 32'(busy), 0);
    chk("t1_hold", 32'(value), 32'h1234);

    // settle S=5, settle change mid-SETTLE ignored
    to_cycle(20);
    settle_cycles = 4'd5;
    src_data = 16'hFF38;
    req = 1'b1;
    push(16'hFF38, 28);
    to_cycle(21);
    req = 1'b0;
    to_cycle(24);
    settle_cycles = 4'd0;
    to_cycle(27);
    #3;
    chk("t2_busy27", 32'(busy), 1);
    chk("t2_hold27", 32'(value), 32'h1234);

    // source stall, 4 cycles
    to_cycle(40);
    req = 1'b1;
    push(16'h0BEE, 47);
    to_cycle(41);
    req = 1'b0;
    src_valid = 1'b0;
    src_data = 16'hDEAD;
    for (int c = 42; c <= 46; c++) begin
      to_cycle(c);
      if (c == 46) begin
        src_valid = 1'b1;
        src_data = 16'h0BEE;
      end
      #3;
      chk("t3_ready", 32'(src_ready), 1);
    end

    // queue fill with overflow, then drain
    to_cycle(59);
    src_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      to_cycle(60 + i);
      req = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      push(16'hA000 + 16'(i), 71 + 2 * i);
    end
    #3;
    chk("t4_ovf68", 32'(overflow), 0);
    chk("t4_pend68", 32'(pending), 7);
    to_cycle(69);
    req = 1'b0;
    #3;
    chk("t4_ovf69", 32'(overflow), 1);
    chk("t4_pend69", 32'(pending), 7);
    for (int i = 0; i < 8; i++) begin
      to_cycle(70 + 2 * i);
      src_valid = 1'b1;
      src_data = 16'hA000 + 16'(i);
    end
    to_cycle(86);
    #3;
    chk("t4_pend86", 32'(pending), 0);
    chk("t4_busy86", 32'(busy), 0);
    chk("t4_ovf86", 32'(overflow), 1);
    to_cycle(87);
    ovf_clr = 1'b1;
    to_cycle(88);
    ovf_clr = 1'b0;
    #3;
    chk("t4_ovfclr", 32'(overflow), 0);

    // req coincident with dequeue in ACK
    to_cycle(99);
    src_data = 16'h5555;
    to_cycle(100);
    req = 1'b1;
    push(16'h5555, 103);
    push(16'h5555, 105);
    push(16'h5555, 107);
    to_cycle(101);
    req = 1'b0;
    to_cycle(102);
    req = 1'b1;
    to_cycle(103);
    #3;
    chk("t5_pend103", 32'(pending), 1);
    to_cycle(104);
    req = 1'b0;
    #3;
    chk("t5_pend104", 32'(pending), 1);
    chk("t5_ready104", 32'(src_ready), 1);

    // reset mid-SETTLE
    to_cycle(119);
    settle_cycles = 4'd6;
    src_data = 16'h6666;
    to_cycle(120);
    req = 1'b1;
    to_cycle(121);
    req = 1'b0;
    to_cycle(122);
    req = 1'b1;
    to_cycle(124);
    req = 1'b0;
    #3;
    chk("t6_pend124", 32'(pending), 2);
    chk("t6_busy124", 32'(busy), 1);
    to_cycle(125);
    rstb = 1'b0;
    #2;
    chk("t6_ack", 32'(ack), 0);
    chk("t6_value", 32'(value), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_pend", 32'(pending), 0);
    chk("t6_ready", 32'(src_ready), 0);
    chk("t6_ovf", 32'(overflow), 0);
    to_cycle(126);
    rstb = 1'b1;
    to_cycle(129);
    src_data = 16'h7777;
    to_cycle(130);
    req = 1'b1;
    push(16'h7777, 139);
    to_cycle(131);
    req = 1'b0;
    to_cycle(140);
    #3;
    chk("t6_hold140", 32'(value), 32'h7777);

    to_cycle(150);
    chk("queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
